// File: rtl/poets_mem_pkg.sv
// Shared constants for the POETS burst memory: FSM state codes and read latency.
package poets_mem_pkg;

  localparam int RD_LATENCY = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_CLEAR = 2'd0;
  localparam state_t ST_IDLE  = 2'd1;
  localparam state_t ST_RD    = 2'd2;
  localparam state_t ST_WR    = 2'd3;

endpackage

// File: rtl/poets_mem_ram.sv
// Single-port byte-enabled synchronous RAM, 1-cycle read, read-old-data on collision.
module poets_mem_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 12800,
  parameter int ADDR_W = 14
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [IDX_W-1:0]  idx;

  // Callers keep addr below DEPTH, so the upper bits are always zero.
  assign idx   = addr[IDX_W-1:0];
  assign rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
      rdata_q <= mem_q[idx];
    end
  end

endmodule

// File: rtl/poets_burst_mem.sv
// Burst-capable word memory with zero-fill after reset and fixed 2-cycle read latency.
module poets_burst_mem
  import poets_mem_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 12800,
  parameter int ADDR_W         = 14,
  parameter int BURST_W        = 4,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reset_req,
  input  logic                clken,
  input  logic [ADDR_W-1:0]   address,
  input  logic [BURST_W-1:0]  burstcount,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  input  logic [DATA_W/8-1:0] byteenable,
  output logic                waitrequest,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                busy_clearing
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [BURST_W-1:0] ONE = BURST_W'(1);

  logic                  en;
  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [BURST_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]     start_addr;
  logic [BURST_W-1:0]    len;
  logic                  ram_en, ram_we;
  logic [ADDR_W-1:0]     ram_addr;
  logic [DATA_W-1:0]     ram_wdata, ram_rdata;
  logic [BE_W-1:0]       ram_be;
  logic                  issue;
  logic                  wait_c;
  logic [RD_LATENCY-1:0] vld_q;
  logic [DATA_W-1:0]     rdata_q;

  function automatic logic [ADDR_W-1:0] inc_wrap(input logic [ADDR_W-1:0] a);
    return (32'(a) == 32'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  assign en         = clken & ~reset_req;
  assign start_addr = ADDR_W'(32'(address) % 32'(DEPTH));
  assign len        = (burstcount == '0) ? ONE : burstcount;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    ram_we        = 1'b0;
    ram_addr      = addr_q;
    ram_wdata     = writedata;
    ram_be        = byteenable;
    issue         = 1'b0;
    wait_c        = 1'b1;
    busy_clearing = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        busy_clearing = 1'b1;
        ram_we        = 1'b1;
        ram_wdata     = '0;
        ram_be        = '1;
        if (32'(addr_q) == 32'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      ST_IDLE: begin
        wait_c = ~en;
        // Write has priority; a simultaneous read is dropped.
        if (write) begin
          ram_we   = 1'b1;
          ram_addr = start_addr;
          if (len != ONE) begin
            state_d = ST_WR;
            addr_d  = inc_wrap(start_addr);
            cnt_d   = len - ONE;
          end
        end else if (read) begin
          issue    = 1'b1;
          ram_addr = start_addr;
          if (len != ONE) begin
            state_d = ST_RD;
            addr_d  = inc_wrap(start_addr);
            cnt_d   = len - ONE;
          end
        end
      end
      ST_RD: begin
        issue  = 1'b1;
        addr_d = inc_wrap(addr_q);
        cnt_d  = cnt_q - ONE;
        if (cnt_q == ONE) state_d = ST_IDLE;
      end
      ST_WR: begin
        wait_c = ~en;
        if (write) begin
          ram_we = 1'b1;
          addr_d = inc_wrap(addr_q);
          cnt_d  = cnt_q - ONE;
          if (cnt_q == ONE) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ram_en = en & ~reset;

  poets_mem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .be    (ram_be),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      vld_q   <= '0;
      rdata_q <= '0;
    end else if (en) begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      vld_q   <= {vld_q[RD_LATENCY-2:0], issue};
      // vld_q[0] marks the RAM output register as holding an issued read.
      if (vld_q[0]) rdata_q <= ram_rdata;
    end
  end

  assign waitrequest   = wait_c | reset;
  assign readdata      = rdata_q;
  assign readdatavalid = vld_q[RD_LATENCY-1];

endmodule
